// File: rtl/seq_counter_param_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : seq_counter_param_pkg                                      |
// | Description : Shared defaults and encodings for the table-driven         |
// |               sequence counter (default table geometry and contents,     |
// |               dir/mode input encodings).                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package seq_counter_param_pkg;

    // Default table geometry and contents; entry 0 lives in the LSBs.
    // Sequence: 000, 001, 011, 101, 111, 010
    localparam int          DEF_WIDTH = 3;
    localparam int          DEF_DEPTH = 6;
    localparam int          DEF_IDXW  = 3;
    localparam logic [17:0] DEF_SEQ   = 18'b010_111_101_011_001_000;

    // mode input encoding
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // dir input encoding
    localparam logic DIR_BWD = 1'b0;
    localparam logic DIR_FWD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seq_counter_table.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_counter_table                                          |
// | Description : Combinational index -> code lookup into a packed table.    |
// |               Indices outside 0..DEPTH-1 return all zeros.               |
// | Ports       : idx  in  IDXW   table index                                |
// |               code out WIDTH  SEQ[idx] (or 0 if out of range)            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module seq_counter_table #(
    parameter int                       WIDTH = 3,
    parameter int                       DEPTH = 6,
    parameter int                       IDXW  = 3,
    parameter logic [WIDTH*DEPTH-1:0]   SEQ   = '0
) (
    input  logic [IDXW-1:0]  idx,
    output logic [WIDTH-1:0] code
);

    always_comb begin
        code = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(idx) == i) begin
                code = SEQ[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_counter_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_counter_param                                          |
// | Description : Sequence counter stepping through a programmable table of  |
// |               DEPTH codes. Forward/backward stepping, wrap or one-shot   |
// |               mode, synchronous index load with clamping, wrap pulse     |
// |               and sticky done flag. All outputs registered.              |
// | Ports       : clk       in   1      rising-edge clock                    |
// |               reset     in   1      async active-high reset              |
// |               enable    in   1      advance one step per clock           |
// |               dir       in   1      1 = forward, 0 = backward            |
// |               mode      in   1      0 = wrap, 1 = one-shot               |
// |               load      in   1      synchronous index load               |
// |               load_idx  in   IDXW   index to load (clamped to DEPTH-1)   |
// |               count     out  WIDTH  SEQ[idx]                             |
// |               idx       out  IDXW   current table index                  |
// |               wrap      out  1      one-cycle pulse on index wrap        |
// |               done      out  1      sticky end-of-table in one-shot      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module seq_counter_param
    import seq_counter_param_pkg::*;
#(
    parameter int                       WIDTH = DEF_WIDTH,
    parameter int                       DEPTH = DEF_DEPTH,
    parameter int                       IDXW  = DEF_IDXW,
    parameter logic [WIDTH*DEPTH-1:0]   SEQ   = DEF_SEQ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [IDXW-1:0]  load_idx,
    output logic [WIDTH-1:0] count,
    output logic [IDXW-1:0]  idx,
    output logic             wrap,
    output logic             done
);

    localparam logic [IDXW-1:0]  c_LAST  = IDXW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] c_CODE0 = SEQ[WIDTH-1:0];

    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_done;

    logic [IDXW-1:0]  w_idx_next;
    logic [WIDTH-1:0] w_code_next;
    logic             w_wrap_next;
    logic             w_done_next;
    logic [IDXW-1:0]  w_load_clamped;

    // Compare in 32 bits so the clamp stays correct when IDXW cannot
    // represent DEPTH itself.
    assign w_load_clamped = (32'(load_idx) >= DEPTH) ? c_LAST : load_idx;

    always_comb begin
        w_idx_next  = r_idx;
        w_wrap_next = 1'b0;
        w_done_next = r_done;
        if (load) begin
            w_idx_next  = w_load_clamped;
            w_done_next = 1'b0;
        end else if (r_done) begin
            // Once done, stepping is frozen; only a wrap-mode edge releases it,
            // and that edge itself does not advance.
            if (mode == MODE_WRAP) begin
                w_done_next = 1'b0;
            end
        end else if (enable) begin
            if (dir == DIR_FWD) begin
                if (r_idx == c_LAST) begin
                    if (mode == MODE_WRAP) begin
                        w_idx_next  = '0;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end else begin
                if (r_idx == '0) begin
                    if (mode == MODE_WRAP) begin
                        w_idx_next  = c_LAST;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end else begin
                    w_idx_next = r_idx - 1'b1;
                end
            end
        end
    end

    // Look up the code for the next index so count tracks idx on the same edge.
    seq_counter_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDXW  (IDXW),
        .SEQ   (SEQ)
    ) u_table (
        .idx  (w_idx_next),
        .code (w_code_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_count <= c_CODE0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_idx   <= w_idx_next;
            r_count <= w_code_next;
            r_wrap  <= w_wrap_next;
            r_done  <= w_done_next;
        end
    end

    assign count = r_count;
    assign idx   = r_idx;
    assign wrap  = r_wrap;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_counter_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_seq_counter_param                                       |
// | Description : Directed self-checking bench for seq_counter_param using   |
// |               the default table (000,001,011,101,111,010).               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_seq_counter_param;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       dir;
    logic       mode;
    logic       load;
    logic [2:0] load_idx;
    logic [2:0] count;
    logic [2:0] idx;
    logic       wrap;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    // Expected codes, hand-written from the default table.
    logic [2:0] exp_seq [6] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b111, 3'b010};

    seq_counter_param dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_idx (load_idx),
        .count    (count),
        .idx      (idx),
        .wrap     (wrap),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        dir      = 1'b1;
        mode     = 1'b0;
        load     = 1'b0;
        load_idx = '0;
        #12;
        check("rst_count", count, 0);
        check("rst_idx",   idx,   0);
        check("rst_wrap",  wrap,  0);
        check("rst_done",  done,  0);
        @(negedge clk);
        reset = 1'b0;

        // 1: forward wrap over six edges
        enable = 1'b1; dir = 1'b1; mode = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("fwd_count%0d", k), count, exp_seq[(k + 1) % 6]);
            check($sformatf("fwd_wrap%0d", k),  wrap,  (k == 5) ? 1 : 0);
        end
        check("fwd_idx_end", idx, 0);

        // 2: backward from reset wraps to the last entry
        do_reset();
        dir = 1'b0;
        step();
        check("bwd_count0", count, 3'b010);
        check("bwd_idx0",   idx,   5);
        check("bwd_wrap0",  wrap,  1);
        step();
        check("bwd_count1", count, 3'b111);
        check("bwd_idx1",   idx,   4);
        check("bwd_wrap1",  wrap,  0);

        // 3: one-shot forward
        do_reset();
        dir = 1'b1; mode = 1'b1;
        repeat (5) step();
        check("os_count5", count, 3'b010);
        check("os_idx5",   idx,   5);
        check("os_done5",  done,  0);
        step();
        check("os_count6", count, 3'b010);
        check("os_done6",  done,  1);
        check("os_wrap6",  wrap,  0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("os_hold_count%0d", k), count, 3'b010);
            check($sformatf("os_hold_done%0d", k),  done,  1);
        end
        mode = 1'b0;
        step();
        check("os_clr_done",  done,  0);
        check("os_clr_count", count, 3'b010);
        check("os_clr_idx",   idx,   5);

        // one-shot backward stops at index 0
        do_reset();
        dir = 1'b0; mode = 1'b1;
        step();
        check("osb_idx",  idx,  0);
        check("osb_done", done, 1);
        check("osb_wrap", wrap, 0);

        // 4: load, clamp, and load clearing done
        load = 1'b1; load_idx = 3'd3; dir = 1'b1;
        step();
        check("ld3_count", count, 3'b101);
        check("ld3_idx",   idx,   3);
        check("ld3_done",  done,  0);
        load_idx = 3'd7;
        step();
        check("ld7_idx",   idx,   5);
        check("ld7_count", count, 3'b010);
        load = 1'b0;
        step();
        check("ld_done_set", done, 1);
        load = 1'b1; load_idx = 3'd0;
        step();
        check("ld_done_clr",  done,  0);
        check("ld0_count",    count, 3'b000);

        // 5: hold with enable low
        load_idx = 3'd2;
        step();
        load = 1'b0; enable = 1'b0; mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("hold_count%0d", k), count, 3'b011);
            check($sformatf("hold_wrap%0d", k),  wrap,  0);
        end
        check("hold_idx", idx, 2);

        // 6: async reset between edges
        load = 1'b1; load_idx = 3'd4;
        step();
        load = 1'b0;
        check("pre_rst_count", count, 3'b111);
        #2;
        reset = 1'b1;
        #1;
        check("async_count", count, 0);
        check("async_idx",   idx,   0);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
